// File: rtl/mac_sched_pkg.sv
// Shared types and default widths for the MAC job scheduler.
package mac_sched_pkg;

    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_AW   = 16;
    localparam int unsigned DEF_LENW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // Index width for n entries, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mac_core.sv
// Signed multiply-accumulate datapath: product register feeding a wrapping accumulator.
module mac_core
    import mac_sched_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_in_valid,
    input  logic          i_clear,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [AW-1:0] o_acc
);

    localparam int unsigned PW = 2 * DW;

    logic signed [DW-1:0] w_a_s;
    logic signed [DW-1:0] w_b_s;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] r_prod;
    logic                 r_prod_vld;
    logic        [AW-1:0] r_acc;

    assign w_a_s  = i_a;
    assign w_b_s  = i_b;
    assign w_prod = PW'(w_a_s) * PW'(w_b_s);

    // Product of a beat lands one edge later; the accumulator folds it in the edge after
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (i_clear) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= i_in_valid;
            if (i_in_valid) begin
                r_prod <= w_prod;
            end
            if (r_prod_vld) begin
                r_acc <= r_acc + AW'(r_prod);
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mac_job_scheduler.sv
// Round-robin scheduler sharing one signed MAC among NREQ dot-product requesters.
module mac_job_scheduler
    import mac_sched_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned LENW = DEF_LENW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*LENW-1:0]     req_len,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          op_valid,
    input  logic [NREQ*DW-1:0]       op_a,
    input  logic [NREQ*DW-1:0]       op_b,
    output logic [NREQ-1:0]          op_ready,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [AW-1:0]            res_data,
    input  logic                     res_ready
);

    localparam int unsigned IDW = idx_w(NREQ);

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_cnt;
    logic            w_any;
    logic [IDW-1:0]  w_gnt;
    logic [LENW-1:0] w_gnt_len;
    logic            w_grant;
    logic            w_beat;
    logic            w_last;
    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;

    // First pending requester strictly after the last granted one, wrapping
    always_comb begin : arb
        logic [IDW-1:0] v_idx;
        w_any = 1'b0;
        w_gnt = '0;
        v_idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            v_idx = IDW'((32'(r_ptr) + i) % NREQ);
            if (!w_any && req_valid[v_idx]) begin
                w_any = 1'b1;
                w_gnt = v_idx;
            end
        end
    end

    assign w_gnt_len = req_len[w_gnt*LENW +: LENW];
    assign w_grant   = (r_state == ST_IDLE) && w_any;
    assign w_beat    = (r_state == ST_RUN) && op_valid[r_id];
    assign w_last    = (r_cnt == (r_len - LENW'(1)));
    assign w_a       = op_a[r_id*DW +: DW];
    assign w_b       = op_b[r_id*DW +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next = (w_gnt_len == '0) ? ST_RESULT : ST_RUN;
            ST_RUN:    if (w_beat && w_last) w_next = ST_DRAIN;
            ST_DRAIN:  w_next = ST_RESULT;
            ST_RESULT: if (res_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        op_ready  = '0;
        res_valid = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_any) req_ready[w_gnt] = 1'b1;
            ST_RUN:    op_ready[r_id] = 1'b1;
            ST_RESULT: res_valid = 1'b1;
            default:   ;
        endcase
    end

    // Job context is captured at grant; the beat counter only advances on real beats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= IDW'(NREQ - 1);
            r_id  <= '0;
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_grant) begin
            r_ptr <= w_gnt;
            r_id  <= w_gnt;
            r_len <= w_gnt_len;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + LENW'(1);
        end
    end

    mac_core #(
        .DW (DW),
        .AW (AW)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (w_beat),
        .i_clear    (w_grant),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_acc      (res_data)
    );

    assign res_id = r_id;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Scoreboard bench for mac_job_scheduler: expected sums queued at grant, checked at result handshake.
module tb_mac_job_scheduler;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_len;
    logic [3:0]  req_ready;
    logic [3:0]  op_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_ready;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_data;
    logic        res_ready;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   op2_cnt = 0;
    logic excl_bad = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    int   ja[16];
    int   jb[16];

    mac_job_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result handshake pops the scoreboard; also watches grant/operand exclusivity
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (req_ready != 4'd0 && op_ready != 4'd0) excl_bad = 1'b1;
            if ($countones(req_ready) > 1 || $countones(op_ready) > 1) excl_bad = 1'b1;
            if (op_ready[2]) op2_cnt++;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("res_id", 32'(res_id), 32'(mon_e.id));
                    check_eq("res_data", 32'(res_data), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic do_job(input int id, input int len, input int gaps, input int abort_at,
                          output int g_cyc);
        int   k;
        int   guard;
        int   sum;
        bit   ok;
        bit   stalled;
        exp_t e;
        sum = 0;
        for (int i = 0; i < len; i++) sum += ja[i] * jb[i];
        req_len[id*8 +: 8] = 8'(len);
        req_valid[id] = 1'b1;
        ok = 1'b0;
        g_cyc = -1;
        for (int t = 0; t < 300; t++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("grant_seen", 32'(ok), 32'd1);
        if (!ok) begin
            req_valid[id] = 1'b0;
            return;
        end
        g_cyc = cyc;
        if (abort_at < 0) begin
            e.id   = 2'(id);
            e.data = 16'(sum);
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
        k = 0;
        guard = 0;
        stalled = 1'b0;
        while (k < len && guard < 300) begin
            if (k == abort_at) break;
            guard++;
            if (gaps[k] && !stalled) begin
                op_valid[id] = 1'b0;
                stalled = 1'b1;
            end else begin
                op_valid[id] = 1'b1;
                op_a[id*8 +: 8] = 8'(ja[k]);
                op_b[id*8 +: 8] = 8'(jb[k]);
            end
            #1;
            if (op_valid[id] && op_ready[id]) begin
                k++;
                stalled = 1'b0;
            end
            @(negedge clk);
        end
        op_valid[id] = 1'b0;
        if (abort_at < 0) check_eq("beats_done", 32'(k), 32'(len));
    endtask

    task automatic wait_res(output int c);
        bit ok;
        ok = 1'b0;
        c = -1;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("res_seen", 32'(ok), 32'd1);
        if (ok) c = cyc;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("drain", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int  g;
        int  c;
        int  h;
        int  gid;
        int  n_op2;
        bit  ok;
        exp_t e;

        reset = 1'b1;
        req_valid = '0;
        req_len = '0;
        op_valid = '0;
        op_a = '0;
        op_b = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_op_ready", 32'(op_ready), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_data", 32'(res_data), 32'd0);
        check_eq("rst_res_id", 32'(res_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Round robin with all four pending; second round restarts at 0
        req_len = {4{8'd1}};
        for (int i = 0; i < 4; i++) begin
            op_a[i*8 +: 8] = 8'(i + 1);
            op_b[i*8 +: 8] = 8'(i + 2);
        end
        op_valid = 4'hF;
        req_valid = 4'hF;
        for (int r = 0; r < 5; r++) begin
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                #1;
                if (req_ready != 4'd0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check_eq("rr_grant_seen", 32'(ok), 32'd1);
            gid = -1;
            for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
            check_eq("rr_order", 32'(gid), 32'(r % 4));
            e.id = 2'(r % 4);
            e.data = 16'((r % 4 + 1) * (r % 4 + 2));
            sb.push_back(e);
            @(negedge clk);
            if (r == 4) req_valid = '0;
        end
        wait_drain();
        op_valid = '0;

        // Basic job with latency check
        ja[0] = 2;  jb[0] = 3;
        ja[1] = -4; jb[1] = 5;
        ja[2] = 7;  jb[2] = 7;
        do_job(0, 3, 0, -1, g);
        wait_res(c);
        check_eq("lat_len3", 32'(c - g), 32'd5);
        wait_drain();

        // Zero-length job: immediate result, no operand phase
        n_op2 = op2_cnt;
        do_job(2, 0, 0, -1, g);
        wait_res(c);
        check_eq("lat_len0", 32'(c - g), 32'd1);
        wait_drain();
        check_eq("len0_no_op_ready", 32'(op2_cnt - n_op2), 32'd0);

        // Accumulator wrap at the most negative operands, then the largest positive product
        for (int i = 0; i < 4; i++) begin
            ja[i] = -128;
            jb[i] = -128;
        end
        do_job(1, 4, 0, -1, g);
        wait_drain();
        ja[0] = 127; jb[0] = 127;
        do_job(3, 1, 0, -1, g);
        wait_drain();

        // Result back-pressure with a pending requester, then a job with operand gaps
        res_ready = 1'b0;
        ja[0] = 5; jb[0] = -2;
        ja[1] = 6; jb[1] = 3;
        do_job(0, 2, 0, -1, g);
        wait_res(c);
        req_len[15:8] = 8'd3;
        req_valid[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check_eq("hold_valid", 32'(res_valid), 32'd1);
            check_eq("hold_data", 32'(res_data), 32'd8);
            check_eq("hold_id", 32'(res_id), 32'd0);
            check_eq("hold_no_grant", 32'(req_ready), 32'd0);
            check_eq("hold_no_op", 32'(op_ready), 32'd0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        check_eq("hs_no_grant", 32'(req_ready), 32'd0);
        h = cyc;
        @(negedge clk);
        ja[0] = 2;  jb[0] = 3;
        ja[1] = -4; jb[1] = 5;
        ja[2] = 7;  jb[2] = 7;
        do_job(1, 3, 5, -1, g);
        check_eq("grant_after_hs", 32'(g - h), 32'd1);
        wait_res(c);
        check_eq("lat_gaps", 32'(c - g), 32'd7);
        wait_drain();

        // Reset in the middle of a job discards it
        ja[0] = 3; jb[0] = 4;
        ja[1] = 5; jb[1] = 6;
        ja[2] = 1; jb[2] = 1;
        ja[3] = 1; jb[3] = 1;
        do_job(2, 4, 0, 2, g);
        #1;
        check_eq("pre_rst_running", 32'(op_ready), 32'h4);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_op_ready", 32'(op_ready), 32'd0);
        check_eq("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("mid_rst_res_data", 32'(res_data), 32'd0);
        check_eq("mid_rst_res_id", 32'(res_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ja[0] = 3; jb[0] = 3;
        do_job(0, 1, 0, -1, g);
        wait_res(c);
        check_eq("lat_after_rst", 32'(c - g), 32'd3);
        wait_drain();

        check_eq("exclusive_ready", 32'(excl_bad), 32'd0);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
